alu_mc: RTL and testbench

//  Parametrised multi-cycle ALU for the sCPU datapath; successor to the 8-bit add/load-imm/compare ALU.

---
 rtl/alu_pkg.sv | 14 +
 rtl/alu_mul_seq.sv | 50 +++++
 rtl/alu_mc.sv | 99 +++++++++
 tb/tb_alu_mc.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Opcode and FSM encodings shared by the multi-cycle ALU and its testbench.
package alu_pkg;
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_LDI = 3'd2;
  localparam logic [2:0] OP_CMP = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_OR  = 3'd5;
  localparam logic [2:0] OP_MUL = 3'd6;
  localparam logic [2:0] OP_NOP = 3'd7;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_MUL  = 1'b1;
endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add multiplier: one partial product per cycle, WIDTH cycles per op.
// done/product/ovf are combinational during the final step so the caller registers them.
module alu_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product,
  output logic             ovf
);
  localparam int CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] mcand_q, acc_q, acc_nxt;
  logic [WIDTH-1:0]   mplr_q;
  logic [CW-1:0]      cnt_q;
  logic               busy_q;

  assign acc_nxt = mplr_q[0] ? acc_q + mcand_q : acc_q;
  assign busy    = busy_q;
  assign done    = busy_q & (cnt_q == '0);
  assign product = acc_nxt[WIDTH-1:0];
  assign ovf     = |acc_nxt[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand_q <= '0;
      acc_q   <= '0;
      mplr_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else if (load) begin
      mcand_q <= {{WIDTH{1'b0}}, A};
      mplr_q  <= B;
      acc_q   <= '0;
      cnt_q   <= CW'(WIDTH - 1);
      busy_q  <= 1'b1;
    end else if (busy_q) begin
      acc_q   <= acc_nxt;
      mcand_q <= mcand_q << 1;
      mplr_q  <= mplr_q >> 1;
      cnt_q   <= cnt_q - 1'b1;
      if (cnt_q == '0) busy_q <= 1'b0;
    end
  end
endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle ops complete on the accepting edge, MUL runs
// through the sequential multiplier; result and flags are registered.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int IMM_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [IMM_W-1:0] imm,
  input  logic [WIDTH-1:0] reg0_val,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             equal,
  output logic             carry,
  output logic             zero
);
  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             equal_q, equal_d, carry_q, carry_d, zero_q, zero_d, done_q, done_d;
  logic             accept, mul_load, mul_busy, mul_done, mul_ovf;
  logic [WIDTH-1:0] mul_product;
  logic [WIDTH:0]   sum;

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk(clk), .reset(reset), .load(mul_load), .A(A), .B(B),
    .busy(mul_busy), .done(mul_done), .product(mul_product), .ovf(mul_ovf)
  );

  assign accept = start & (state_q == ST_IDLE);
  assign sum    = {1'b0, A} + {1'b0, B};

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    equal_d  = equal_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    done_d   = 1'b0;
    mul_load = 1'b0;
    if (state_q == ST_MUL) begin
      if (mul_done) begin
        result_d = mul_product;
        carry_d  = mul_ovf;
        zero_d   = (mul_product == '0);
        done_d   = 1'b1;
        state_d  = ST_IDLE;
      end
    end else if (accept) begin
      done_d = 1'b1;
      case (op)
        OP_ADD: begin result_d = sum[WIDTH-1:0]; carry_d = sum[WIDTH]; end
        OP_SUB: begin result_d = A - B;          carry_d = (A >= B);  end
        OP_LDI: begin result_d = WIDTH'(imm);    carry_d = 1'b0;      end
        OP_AND: begin result_d = A & B;          carry_d = 1'b0;      end
        OP_OR:  begin result_d = A | B;          carry_d = 1'b0;      end
        OP_CMP: equal_d = (B == reg0_val);
        OP_MUL: begin
          done_d   = 1'b0;
          mul_load = 1'b1;
          state_d  = ST_MUL;
        end
        default: ;
      endcase
      if (op != OP_CMP && op != OP_NOP && op != OP_MUL) zero_d = (result_d == '0);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      equal_q  <= 1'b0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      equal_q  <= equal_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      done_q   <= done_d;
    end
  end

  assign busy   = mul_busy;
  assign done   = done_q;
  assign result = result_q;
  assign equal  = equal_q;
  assign carry  = carry_q;
  assign zero   = zero_q;
endmodule

// File: tb/tb_alu_mc.sv
// Directed checks of alu_mc (WIDTH=8, IMM_W=4) with hand-computed expectations.
module tb_alu_mc;
  import alu_pkg::*;

  logic       clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [2:0] op = OP_NOP;
  logic [7:0] A = '0, B = '0, reg0_val = '0, result;
  logic [3:0] imm = '0;
  logic       busy, done, equal, carry, zero;
  int         total = 0, bad = 0;

  alu_mc #(.WIDTH(8), .IMM_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B), .imm(imm),
    .reg0_val(reg0_val), .busy(busy), .done(done), .result(result),
    .equal(equal), .carry(carry), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Present one op with start for a single edge; return sampled #1 after that edge.
  task automatic issue(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                       input logic [3:0] im, input logic [7:0] r0);
    op = o; A = a; B = b; imm = im; reg0_val = r0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; A = 8'hAA; B = 8'h55;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    int ndone;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_result", result, 0);
    chk("rst_flags", {busy, done, equal, carry, zero}, 0);
    reset = 1'b0;
    tick();

    issue(OP_ADD, 8'hF0, 8'h20, 0, 0);
    chk("add_done", done, 1);
    chk("add_res", result, 8'h10);
    chk("add_cz", {carry, zero}, 2'b10);
    tick();
    chk("add_done_pulse", done, 0);

    issue(OP_SUB, 8'h05, 8'h05, 0, 0);
    chk("sub_eq_res", result, 8'h00);
    chk("sub_eq_cz", {carry, zero}, 2'b11);
    issue(OP_SUB, 8'h03, 8'h05, 0, 0);
    chk("sub_lt_res", result, 8'hFE);
    chk("sub_lt_cz", {carry, zero}, 2'b00);

    issue(OP_NOP, 0, 0, 0, 0);
    chk("nop_done", done, 1);
    chk("nop_res", result, 8'hFE);

    issue(OP_AND, 8'hCC, 8'hAA, 0, 0);
    chk("and_res", result, 8'h88);
    issue(OP_OR, 8'h0C, 8'h30, 0, 0);
    chk("or_res", result, 8'h3C);

    issue(OP_LDI, 0, 0, 4'hA, 0);
    chk("ldi_res", result, 8'h0A);
    issue(OP_CMP, 0, 8'h33, 0, 8'h33);
    chk("cmp_done", done, 1);
    chk("cmp_eq", equal, 1);
    chk("cmp_res", result, 8'h0A);

    // 13*11 = 143: busy through cycle 7, done at cycle 8
    issue(OP_MUL, 8'd13, 8'd11, 0, 0);
    chk("mul_busy0", {busy, done}, 2'b10);
    for (int k = 1; k < 8; k++) begin
      tick();
      chk($sformatf("mul_busy%0d", k), {busy, done}, 2'b10);
    end
    tick();
    chk("mul_done", {busy, done}, 2'b01);
    chk("mul_res", result, 8'h8F);
    chk("mul_cz", {carry, zero}, 2'b00);

    // start during MUL is ignored; ADD issued in the done cycle completes next
    issue(OP_MUL, 8'd3, 8'd5, 0, 0);
    ndone = 0;
    for (int k = 1; k < 8; k++) begin
      if (k == 3) begin
        op = OP_ADD; A = 8'd1; B = 8'd1; start = 1'b1;
      end else start = 1'b0;
      tick();
      ndone += int'(done);
    end
    start = 1'b0;
    chk("ign_no_done", ndone, 0);
    tick();
    chk("ign_done", done, 1);
    chk("ign_res", result, 8'h0F);
    issue(OP_ADD, 8'd2, 8'd3, 0, 0);
    chk("b2b_done", done, 1);
    chk("b2b_res", result, 8'h05);
    tick();
    chk("b2b_pulse", done, 0);

    issue(OP_MUL, 8'h10, 8'h10, 0, 0);
    repeat (8) tick();
    chk("mulovf_done", done, 1);
    chk("mulovf_res", result, 8'h00);
    chk("mulovf_cz", {carry, zero}, 2'b11);

    // Reset mid-MUL with nonzero result and flags
    issue(OP_ADD, 8'hFF, 8'h02, 0, 0);
    issue(OP_CMP, 0, 8'h44, 0, 8'h44);
    chk("pre_rst", {result, equal, carry, zero}, {8'h01, 3'b110});
    issue(OP_MUL, 8'd13, 8'd11, 0, 0);
    repeat (4) tick();
    reset = 1'b1;
    #1;
    chk("midrst_async", {busy, done, result, equal, carry, zero}, 0);
    tick();
    reset = 1'b0;
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      ndone += int'(done) + int'(busy);
    end
    chk("midrst_no_done", ndone, 0);
    chk("midrst_res", result, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
